// File: rtl/nios2_sopc_po_knn_start_ctrl.sv
// Avalon-MM start/K/status controller for the KNN core: launches a run with a
// one-cycle start pulse, counts busy cycles and keeps done/overrun sticky flags.
//
// state | meaning
// IDLE  | no run active; K may be loaded, start write accepted
// START | one-cycle knn_start pulse, clears done flag and cycle count
// BUSY  | waiting for knn_done, counting cycles
module nios2_sopc_po_knn_start_ctrl #(
  parameter int K_WIDTH   = 8,
  parameter int K_RESET   = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               knn_start,
  output logic [K_WIDTH-1:0] knn_k,
  input  logic               knn_done
);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

  state_e               state_q, state_d;
  logic [K_WIDTH-1:0]   k_q, k_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic [31:0]          readdata_q, readdata_d;

  logic wr, start_wr, k_wr, clr_wr, busy;
  logic unused_wdata;

  assign wr       = chipselect & ~write_n;
  assign start_wr = wr & (address == 2'd0) & writedata[0];
  assign k_wr     = wr & (address == 2'd1);
  assign clr_wr   = wr & (address == 2'd2);
  assign busy     = (state_q != IDLE);

  // Not every write-data bit has a meaning; fold them so none is left dangling.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= K_WIDTH'(K_RESET);
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      readdata_q <= readdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    knn_start = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: if (start_wr) state_d = START;
      START: begin
        knn_start = 1'b1;
        cnt_d     = '0;
        state_d   = BUSY;
      end
      BUSY: begin
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (knn_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: clears are applied first so a same-cycle set wins.
  always_comb begin
    done_d = done_q;
    ovr_d  = ovr_q;
    k_d    = k_q;
    if (clr_wr && writedata[1]) done_d = 1'b0;
    if (clr_wr && writedata[2]) ovr_d  = 1'b0;
    if (state_q == START) done_d = 1'b0;
    if (state_q == BUSY && knn_done) done_d = 1'b1;
    if (busy && (start_wr || k_wr)) ovr_d = 1'b1;
    if (!busy && k_wr) k_d = writedata[K_WIDTH-1:0];
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d = {29'd0, ovr_q, done_q, busy};
      2'd1:    readdata_d = 32'(k_q);
      2'd2:    readdata_d = '0;
      default: readdata_d = 32'(cnt_q);
    endcase
  end

  assign readdata = readdata_q;
  assign knn_k    = k_q;

endmodule
